hfg_rect_accum: RTL and testbench
=================================

// Module: hfg_rect_accum
// PURPOSE
//  Parametrised successor to the single-rectangle Haar sum stage. Takes a stream
//  of rectangle corner quadruples from the integral-image fetch logic. Each beat
//  carries a signed weight. The block accumulates the weighted rectangle sums of
//  one Haar feature (2..MAX_RECT rects), then compares the result with the node
//  threshold. It emits feature value + decision to the classifier stage.
//  Valid/ready on both sides.
// PARAMETERS
//  DATA_W    21  width of integral-image corner values and of one rectangle sum
//  WEIGHT_W  4   width of signed per-rectangle weight (two's complement)
//  MAX_RECT  3   max rectangles per feature; range 2..7
//  ACC_W     DATA_W+WEIGHT_W+3  signed accumulator / oSum width (derived, do not override)
// PORTS
//  iClk      in   1         clock, all logic on rising edge
//  iReset_n  in   1         synchronous, active-low reset
//  iValid    in   1         input beat valid
//  oReady    out  1         block accepts beat when iValid&&oReady
//  iA,iB,iC,iD in DATA_W    corners: A top-left, B top-right, C bottom-left, D bottom-right
//  iWeight   in   WEIGHT_W  signed weight of this rectangle
//  iLast     in   1         last rectangle of the current feature
//  iThresh   in   ACC_W     signed node threshold, sampled on the iLast beat only
//  oValid    out  1         result valid, held until iReady
//  iReady    in   1         downstream accepts result when oValid&&iReady
//  oSum      out  ACC_W     signed weighted feature sum
//  oAbove    out  1         1 when oSum >= threshold (signed compare)
//  oErr      out  1         feature truncated at MAX_RECT (no iLast seen)
// BEHAVIOUR
//  - Reset: oValid=0, oSum=0, oAbove=0, oErr=0, oReady=1; accumulator, rect count
//    and stage-1 valid cleared; FSM -> ACCUM. Reset mid-feature discards partial sum.
//  - Stage 1 (on accept): rect = (iD+iA)-(iB+iC), unsigned, modulo 2^DATA_W.
//    Also registers weight, last, thresh and the force-last flag.
//  - Stage 2: prod = $signed({1'b0,rect}) * $signed(weight), sign-extended to ACC_W.
//    acc_next = (first beat of feature ? 0 : acc) + prod. No saturation; ACC_W
//    guarantees no overflow for MAX_RECT<=7.
//  - Rect counter counts accepted beats of the current feature.
//  - Force-last: the MAX_RECT-th beat with iLast=0 is treated as last. Its result
//    carries oErr=1 and the threshold is taken from that beat.
//    Every other result carries oErr=0.
//  - FSM:
//    ACCUM: oReady=1. Accepting a last (or forced-last) beat -> DRAIN, oReady=0
//      from the next cycle.
//    DRAIN: stage 2 finishes; the cycle after the beat, load oSum/oAbove/oErr,
//      set oValid=1 -> HOLD.
//    HOLD: oValid=1, outputs stable. iReady=1 -> oValid=0 next cycle, count=0,
//      -> ACCUM.
//  - Latency: last beat accepted at edge t -> oValid=1 after edge t+2.
//  - Throughput: a feature of N rects takes N+3 cycles with iReady tied high.
//  - oReady is 0 in DRAIN and HOLD. Non-last beats never stall in ACCUM.
//  - iValid=0 gaps within a feature are allowed; the partial sum is held.
//  - Inputs are ignored when iValid&&oReady is false. iThresh is ignored on
//    non-last beats.
//  - Single-rect feature (iLast on first beat) is legal: oSum = weight*rect.
// TESTING
//  1 Reset, then a 2-rect feature: rect1 A=0,B=0,C=0,D=100 w=-1; rect2 A=10,B=20,
//    C=30,D=140 w=+2 (rect=100), thresh=50, iReady=1 -> oSum=100, oAbove=1,
//    oErr=0, oValid 2 cycles after last beat.
//  2 Same feature, thresh=101 -> oAbove=0. thresh=100 -> oAbove=1 (equality boundary).
//  3 Wrap: A=0x1FFFFF,B=0,C=0,D=1, w=1 (rect=0 mod 2^21) -> oSum=0.
//    Max weight -8 with rect=0x1FFFFF x3 rects -> oSum=-50331624, no overflow.
//  4 4 beats with no iLast, MAX_RECT=3 -> result after beat 3 with oErr=1.
//    Beat 4 starts a new feature; its result has oErr=0.
//  5 Backpressure: iReady=0 for 5 cycles while oValid -> oSum/oAbove stable,
//    oReady=0; next feature accepted only the cycle after the iReady=1 handshake.
//  6 iReset_n low for 1 cycle after rect1 of a 3-rect feature -> outputs zero,
//    oReady=1; next full feature result excludes the pre-reset rect.

Source files
------------

// File: rtl/hfg_rect_accum.sv
// Weighted multi-rectangle Haar feature accumulator: rectangle sum, weighting,
// per-feature accumulation and signed threshold decision, valid/ready on both sides.
module hfg_rect_accum #(
  parameter int DATA_W   = 21,
  parameter int WEIGHT_W = 4,
  parameter int MAX_RECT = 3
) (
  input  logic                                iClk,
  input  logic                                iReset_n,
  input  logic                                iValid,
  output logic                                oReady,
  input  logic [DATA_W-1:0]                   iA,
  input  logic [DATA_W-1:0]                   iB,
  input  logic [DATA_W-1:0]                   iC,
  input  logic [DATA_W-1:0]                   iD,
  input  logic signed [WEIGHT_W-1:0]          iWeight,
  input  logic                                iLast,
  input  logic signed [DATA_W+WEIGHT_W+2:0]   iThresh,
  output logic                                oValid,
  input  logic                                iReady,
  output logic signed [DATA_W+WEIGHT_W+2:0]   oSum,
  output logic                                oAbove,
  output logic                                oErr
);

  localparam int ACC_W  = DATA_W + WEIGHT_W + 3;
  localparam int PROD_W = DATA_W + WEIGHT_W + 1;
  localparam int CNT_W  = $clog2(MAX_RECT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_RECT - 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_ready;
  logic [CNT_W-1:0]           r_cnt;
  logic [DATA_W-1:0]          r_rect;
  logic signed [WEIGHT_W-1:0] r_weight;
  logic signed [ACC_W-1:0]    r_thresh;
  logic                       r_force;
  logic                       r_first;
  logic                       r_s1_valid;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_valid;
  logic signed [ACC_W-1:0]    r_sum;
  logic                       r_above;
  logic                       r_err;

  logic                       w_accept;
  logic                       w_force;
  logic                       w_is_last;
  logic [DATA_W-1:0]          w_rect;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic                       w_load;
  logic                       w_release;

  // The MAX_RECT-th beat without iLast closes the feature as a truncated one.
  assign w_accept   = iValid && r_ready;
  assign w_force    = !iLast && (r_cnt == LAST_CNT);
  assign w_is_last  = iLast || w_force;
  assign w_rect     = (iD + iA) - (iB + iC);
  assign w_prod     = PROD_W'($signed({1'b0, r_rect})) * PROD_W'(r_weight);
  assign w_prod_ext = ACC_W'(w_prod);

  // FSM state register
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_state <= ST_ACCUM;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next == ST_ACCUM);
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept && w_is_last) w_state_next = ST_DRAIN;
        else                       w_state_next = ST_ACCUM;
      end
      ST_DRAIN: begin
        if (!r_s1_valid) w_state_next = ST_HOLD;
        else             w_state_next = ST_DRAIN;
      end
      ST_HOLD: begin
        if (iReady) w_state_next = ST_ACCUM;
        else        w_state_next = ST_HOLD;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  // FSM output decode: result load once stage 2 has drained, release on handshake
  always_comb begin
    w_load    = 1'b0;
    w_release = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_load    = 1'b0;
        w_release = 1'b0;
      end
      ST_DRAIN: w_load    = !r_s1_valid;
      ST_HOLD:  w_release = iReady;
      default: begin
        w_load    = 1'b0;
        w_release = 1'b0;
      end
    endcase
  end

  // Stage 1: rectangle sum and side-band capture on accept
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_s1_valid <= 1'b0;
      r_rect     <= {DATA_W{1'b0}};
      r_weight   <= {WEIGHT_W{1'b0}};
      r_thresh   <= {ACC_W{1'b0}};
      r_force    <= 1'b0;
      r_first    <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_rect     <= w_rect;
      r_weight   <= iWeight;
      r_first    <= (r_cnt == {CNT_W{1'b0}});
      if (w_is_last) begin
        r_thresh <= iThresh;
        r_force  <= w_force;
      end else begin
        r_thresh <= r_thresh;
        r_force  <= r_force;
      end
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  // Rectangle counter for the feature in flight
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_release) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Stage 2: weighted accumulation, restarting on the first rectangle
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (r_s1_valid) begin
      r_acc <= (r_first ? {ACC_W{1'b0}} : r_acc) + w_prod_ext;
    end else begin
      r_acc <= r_acc;
    end
  end

  // Result registers held stable until the downstream handshake
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_valid <= 1'b0;
      r_sum   <= {ACC_W{1'b0}};
      r_above <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_sum   <= r_acc;
      r_above <= (r_acc >= r_thresh);
      r_err   <= r_force;
    end else if (w_release) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign oReady = r_ready;
  assign oValid = r_valid;
  assign oSum   = r_sum;
  assign oAbove = r_above;
  assign oErr   = r_err;

endmodule

// File: tb/tb_hfg_rect_accum.sv
// Directed bench for hfg_rect_accum: hand-computed feature sums, threshold
// boundaries, wrap, truncation, backpressure and mid-feature reset.
module tb_hfg_rect_accum;

  localparam int DATA_W   = 21;
  localparam int WEIGHT_W = 4;
  localparam int MAX_RECT = 3;
  localparam int ACC_W    = DATA_W + WEIGHT_W + 3;

  logic                       iClk;
  logic                       iReset_n;
  logic                       iValid;
  logic                       oReady;
  logic [DATA_W-1:0]          iA, iB, iC, iD;
  logic signed [WEIGHT_W-1:0] iWeight;
  logic                       iLast;
  logic signed [ACC_W-1:0]    iThresh;
  logic                       oValid;
  logic                       iReady;
  logic signed [ACC_W-1:0]    oSum;
  logic                       oAbove;
  logic                       oErr;

  int checks = 0;
  int errors = 0;

  hfg_rect_accum #(
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .MAX_RECT(MAX_RECT)
  ) dut (
    .iClk    (iClk),
    .iReset_n(iReset_n),
    .iValid  (iValid),
    .oReady  (oReady),
    .iA      (iA),
    .iB      (iB),
    .iC      (iC),
    .iD      (iD),
    .iWeight (iWeight),
    .iLast   (iLast),
    .iThresh (iThresh),
    .oValid  (oValid),
    .iReady  (iReady),
    .oSum    (oSum),
    .oAbove  (oAbove),
    .oErr    (oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d,
                           input logic signed [WEIGHT_W-1:0] w, input logic last,
                           input logic signed [ACC_W-1:0] th);
    int n;
    n = 0;
    iA = a; iB = b; iC = c; iD = d;
    iWeight = w; iLast = last; iThresh = th;
    iValid = 1'b1;
    while (!oReady && n < 50) begin
      @(negedge iClk);
      n++;
    end
    check("accept_timeout", (n < 50) ? 1 : 0, 1);
    @(negedge iClk);
    iValid = 1'b0;
    iLast  = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic signed [ACC_W-1:0] exp_sum,
                            input logic exp_above, input logic exp_err);
    int cyc;
    cyc = 0;
    while (!oValid && cyc < 20) begin
      @(negedge iClk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 2);
    check({tag, "_sum"}, oSum, exp_sum);
    check({tag, "_above"}, oAbove, exp_above);
    check({tag, "_err"}, oErr, exp_err);
    check({tag, "_ready_low"}, oReady, 0);
  endtask

  task automatic release_result(input string tag);
    iReady = 1'b1;
    @(negedge iClk);
    check({tag, "_valid_drop"}, oValid, 0);
    check({tag, "_ready_back"}, oReady, 1);
  endtask

  initial begin
    iReset_n = 1'b0;
    iValid = 1'b0; iLast = 1'b0; iReady = 1'b1;
    iA = '0; iB = '0; iC = '0; iD = '0; iWeight = '0; iThresh = '0;
    repeat (3) @(negedge iClk);
    check("rst_valid", oValid, 0);
    check("rst_sum", oSum, 0);
    check("rst_above", oAbove, 0);
    check("rst_err", oErr, 0);
    check("rst_ready", oReady, 1);
    iReset_n = 1'b1;
    @(negedge iClk);

    // Two-rect feature: -1*100 + 2*100 = 100
    send_beat(21'd0, 21'd0, 21'd0, 21'd100, -4'sd1, 1'b0, 28'sd0);
    send_beat(21'd10, 21'd20, 21'd30, 21'd140, 4'sd2, 1'b1, 28'sd50);
    get_result("t1", 28'sd100, 1'b1, 1'b0);
    release_result("t1");

    send_beat(21'd0, 21'd0, 21'd0, 21'd100, -4'sd1, 1'b0, 28'sd0);
    send_beat(21'd10, 21'd20, 21'd30, 21'd140, 4'sd2, 1'b1, 28'sd101);
    get_result("t2_th101", 28'sd100, 1'b0, 1'b0);
    release_result("t2_th101");

    send_beat(21'd0, 21'd0, 21'd0, 21'd100, -4'sd1, 1'b0, 28'sd0);
    send_beat(21'd10, 21'd20, 21'd30, 21'd140, 4'sd2, 1'b1, 28'sd100);
    get_result("t2_th100", 28'sd100, 1'b1, 1'b0);
    release_result("t2_th100");

    // Corner arithmetic wraps to 0; threshold 0 makes the equality case true
    send_beat(21'h1FFFFF, 21'd0, 21'd0, 21'd1, 4'sd1, 1'b1, 28'sd0);
    get_result("t3_wrap", 28'sd0, 1'b1, 1'b0);
    release_result("t3_wrap");

    // 3 * (-8 * 2097151) = -50331624
    send_beat(21'd0, 21'd0, 21'd0, 21'h1FFFFF, -4'sd8, 1'b0, 28'sd0);
    send_beat(21'd0, 21'd0, 21'd0, 21'h1FFFFF, -4'sd8, 1'b0, 28'sd0);
    send_beat(21'd0, 21'd0, 21'd0, 21'h1FFFFF, -4'sd8, 1'b1, 28'sd0);
    get_result("t3_maxneg", -28'sd50331624, 1'b0, 1'b0);
    release_result("t3_maxneg");

    // Truncated feature: 1+2+3 = 6, threshold taken from the third beat
    send_beat(21'd0, 21'd0, 21'd0, 21'd1, 4'sd1, 1'b0, 28'sd1000);
    send_beat(21'd0, 21'd0, 21'd0, 21'd2, 4'sd1, 1'b0, 28'sd1000);
    send_beat(21'd0, 21'd0, 21'd0, 21'd3, 4'sd1, 1'b0, 28'sd6);
    get_result("t4_trunc", 28'sd6, 1'b1, 1'b1);
    release_result("t4_trunc");
    // Fourth beat opens a new feature: 5 + 2*7 = 19
    send_beat(21'd0, 21'd0, 21'd0, 21'd5, 4'sd1, 1'b0, 28'sd0);
    send_beat(21'd0, 21'd0, 21'd0, 21'd7, 4'sd2, 1'b1, 28'sd100);
    get_result("t4_next", 28'sd19, 1'b0, 1'b0);
    release_result("t4_next");

    // Backpressure: result held for 5 cycles with iReady low
    iReady = 1'b0;
    send_beat(21'd0, 21'd0, 21'd0, 21'd10, 4'sd1, 1'b0, 28'sd0);
    send_beat(21'd0, 21'd0, 21'd0, 21'd20, 4'sd1, 1'b1, 28'sd30);
    get_result("t5", 28'sd30, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge iClk);
      check("t5_hold_valid", oValid, 1);
      check("t5_hold_sum", oSum, 30);
      check("t5_hold_above", oAbove, 1);
      check("t5_hold_ready", oReady, 0);
    end
    release_result("t5");

    // Reset after the first rectangle discards it
    send_beat(21'd0, 21'd0, 21'd0, 21'd1000, 4'sd1, 1'b0, 28'sd0);
    iReset_n = 1'b0;
    @(negedge iClk);
    iReset_n = 1'b1;
    check("t6_valid", oValid, 0);
    check("t6_sum", oSum, 0);
    check("t6_above", oAbove, 0);
    check("t6_err", oErr, 0);
    check("t6_ready", oReady, 1);
    send_beat(21'd0, 21'd0, 21'd0, 21'd100, 4'sd3, 1'b0, 28'sd0);
    send_beat(21'd0, 21'd0, 21'd0, 21'd50, -4'sd1, 1'b1, 28'sd0);
    get_result("t6_after", 28'sd250, 1'b1, 1'b0);
    release_result("t6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
